// File: rtl/png_chunk_crc_if.sv
// Payload-in and CRC-out handshake bundle for png_chunk_crc.
interface png_chunk_crc_if #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned LEN_WD  = 32
);
    localparam int unsigned NB = DATA_WD / 8;

    logic               val_i;
    logic               rdy_o;
    logic [DATA_WD-1:0] dat_i;
    logic [NB-1:0]      keep_i;
    logic               lst_i;
    logic               eof_i;
    logic               crc_val_o;
    logic               crc_rdy_i;
    logic [31:0]        crc_dat_o;
    logic [1:0]         crc_typ_o;
    logic [LEN_WD-1:0]  len_o;

    modport master (
        output val_i, dat_i, keep_i, lst_i, eof_i, crc_rdy_i,
        input  rdy_o, crc_val_o, crc_dat_o, crc_typ_o, len_o
    );

    modport slave (
        input  val_i, dat_i, keep_i, lst_i, eof_i, crc_rdy_i,
        output rdy_o, crc_val_o, crc_dat_o, crc_typ_o, len_o
    );
endinterface

// File: rtl/png_chunk_crc.sv
// PNG chunk CRC32 sequencer: IHDR, IDAT..., IEND with internally injected type words.
// Optional chunk length counter enabled by defining PNG_CRC_LEN_EN.
module png_chunk_crc #(
    parameter int unsigned DATA_WD     = 32,
    parameter int unsigned SIZE_PIC_WD = 32,
    parameter int unsigned LEN_WD      = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SIZE_PIC_WD-1:0] w_i,
    input  logic [SIZE_PIC_WD-1:0] h_i,
    input  logic [7:0]             bit_depth_i,
    input  logic [7:0]             color_type_i,
    input  logic                   start_i,
    output logic                   busy_o,
    png_chunk_crc_if.slave         bus
);
    localparam int unsigned NB        = DATA_WD / 8;
    localparam logic [31:0] POLY      = 32'hEDB88320;
    localparam logic [31:0] ALL1      = 32'hFFFFFFFF;
    localparam logic [31:0] IHDR_W    = 32'h49484452;
    localparam logic [31:0] IDAT_W    = 32'h49444154;
    localparam logic [31:0] IEND_W    = 32'h49454E44;
    localparam logic [NB-1:0] KEEP4   = NB'(4'hF) << (NB - 4);
    localparam logic [NB-1:0] KEEP1   = NB'(1) << (NB - 1);
    localparam logic [NB-1:0] KEEPALL = '1;

    typedef enum logic [2:0] {IDLE, HDR, TYP, DAT, END, OUT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  typ_q, typ_d;
    logic        eof_q, eof_d;
    logic [31:0] w_q, w_d, h_q, h_d;
    logic [7:0]  bd_q, bd_d, ct_q, ct_d;
    logic        rdy_q, rdy_d, val_q, val_d, busy_q, busy_d;
    logic [31:0] hdr_word;
    logic        beat_fire;

    // Reflected CRC-32 over the masked bytes of one beat, MSB byte first.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [DATA_WD-1:0] d,
                                            input logic [NB-1:0] k);
        logic [31:0]        r;
        logic [DATA_WD-1:0] dd;
        logic [NB-1:0]      kk;
        r  = c;
        dd = d;
        kk = k;
        for (int i = 0; i < int'(NB); i++) begin
            if (kk[NB-1]) begin
                r = r ^ {24'h0, dd[DATA_WD-1 -: 8]};
                for (int b = 0; b < 8; b++) begin
                    r = {1'b0, r[31:1]} ^ (r[0] ? POLY : 32'h0);
                end
            end
            dd = dd << 8;
            kk = kk << 1;
        end
        return r;
    endfunction

    function automatic logic [DATA_WD-1:0] widen(input logic [31:0] x);
        return DATA_WD'(x) << (DATA_WD - 32);
    endfunction

    assign beat_fire = bus.val_i && rdy_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= '0;
            res_q   <= '0;
            typ_q   <= '0;
            eof_q   <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            bd_q    <= '0;
            ct_q    <= '0;
            rdy_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            res_q   <= res_d;
            typ_q   <= typ_d;
            eof_q   <= eof_d;
            w_q     <= w_d;
            h_q     <= h_d;
            bd_q    <= bd_d;
            ct_q    <= ct_d;
            rdy_q   <= rdy_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        res_d    = res_q;
        typ_d    = typ_q;
        eof_d    = eof_q;
        w_d      = w_q;
        h_d      = h_q;
        bd_d     = bd_q;
        ct_d     = ct_q;
        hdr_word = 32'h0;
        case (state_q)
            IDLE: if (start_i) begin
                w_d     = 32'(w_i);
                h_d     = 32'(h_i);
                bd_d    = bit_depth_i;
                ct_d    = color_type_i;
                cnt_d   = 3'd0;
                state_d = HDR;
            end
            HDR: begin
                case (cnt_q)
                    3'd0:    hdr_word = IHDR_W;
                    3'd1:    hdr_word = w_q;
                    3'd2:    hdr_word = h_q;
                    3'd3:    hdr_word = {bd_q, ct_q, 16'h0};
                    default: hdr_word = 32'h0;
                endcase
                // last IHDR word carries only the interlace byte
                crc_d = crc_upd((cnt_q == 3'd0) ? ALL1 : crc_q, widen(hdr_word),
                                (cnt_q == 3'd4) ? KEEP1 : KEEP4);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    res_d   = ~crc_d;
                    typ_d   = 2'd0;
                    state_d = OUT;
                end
            end
            TYP: begin
                crc_d   = crc_upd(ALL1, widen(IDAT_W), KEEP4);
                state_d = DAT;
            end
            DAT: if (beat_fire) begin
                crc_d = crc_upd(crc_q, bus.dat_i, bus.lst_i ? bus.keep_i : KEEPALL);
                if (bus.lst_i) begin
                    res_d   = ~crc_d;
                    typ_d   = 2'd1;
                    eof_d   = bus.eof_i;
                    state_d = OUT;
                end
            end
            END: begin
                crc_d   = crc_upd(ALL1, widen(IEND_W), KEEP4);
                res_d   = ~crc_d;
                typ_d   = 2'd2;
                state_d = OUT;
            end
            OUT: if (bus.crc_rdy_i) begin
                case (typ_q)
                    2'd0:    state_d = TYP;
                    2'd1:    state_d = eof_q ? END : TYP;
                    default: state_d = IDLE;
                endcase
            end
            default: state_d = IDLE;
        endcase
        rdy_d  = (state_d == DAT);
        val_d  = (state_d == OUT);
        busy_d = (state_d != IDLE);
    end

    assign bus.rdy_o     = rdy_q;
    assign bus.crc_val_o = val_q;
    assign bus.crc_dat_o = res_q;
    assign bus.crc_typ_o = typ_q;
    assign busy_o        = busy_q;

`ifdef PNG_CRC_LEN_EN
    logic [LEN_WD-1:0] len_cnt_q, len_cnt_d, len_res_q, len_res_d;

    function automatic int unsigned popcnt(input logic [NB-1:0] k);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(NB); i++) n += int'(k[i]);
        return n;
    endfunction

    // Byte count of the current chunk; presented alongside each CRC.
    always_comb begin
        len_cnt_d = len_cnt_q;
        len_res_d = len_res_q;
        case (state_q)
            HDR: if (cnt_q == 3'd4) len_res_d = LEN_WD'(13);
            TYP: len_cnt_d = '0;
            DAT: if (beat_fire) begin
                len_cnt_d = len_cnt_q + (bus.lst_i ? LEN_WD'(popcnt(bus.keep_i)) : LEN_WD'(NB));
                if (bus.lst_i) len_res_d = len_cnt_d;
            end
            END: len_res_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            len_cnt_q <= '0;
            len_res_q <= '0;
        end else begin
            len_cnt_q <= len_cnt_d;
            len_res_q <= len_res_d;
        end
    end

    assign bus.len_o = len_res_q;
`else
    assign bus.len_o = LEN_WD'(0);
`endif
endmodule

// File: tb/tb_png_chunk_crc.sv
// Directed bench for png_chunk_crc: 32-bit and 64-bit instances against a byte-level CRC model.
module tb_png_chunk_crc;
    typedef struct {
        logic [31:0] crc;
        logic [1:0]  typ;
        logic [31:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] w, h;
    logic [7:0]  bd, ct;
    logic        start32, start64;
    logic        busy32, busy64;
    int          errors = 0;
    int          checks = 0;
    exp_t        q32[$];
    logic [31:0] beats[$];
    logic [7:0]  bytes_q[$];
    int          lat;
    int          n;

    png_chunk_crc_if #(.DATA_WD(32), .LEN_WD(32)) b32 ();
    png_chunk_crc_if #(.DATA_WD(64), .LEN_WD(32)) b64 ();

    png_chunk_crc #(.DATA_WD(32), .SIZE_PIC_WD(32), .LEN_WD(32)) dut32 (
        .clk(clk), .rstn(rstn), .w_i(w), .h_i(h), .bit_depth_i(bd), .color_type_i(ct),
        .start_i(start32), .busy_o(busy32), .bus(b32.slave));

    png_chunk_crc #(.DATA_WD(64), .SIZE_PIC_WD(32), .LEN_WD(32)) dut64 (
        .clk(clk), .rstn(rstn), .w_i(w), .h_i(h), .bit_depth_i(bd), .color_type_i(ct),
        .start_i(start64), .busy_o(busy64), .bus(b64.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c ^= {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] exp_len(input int unsigned nbytes);
`ifdef PNG_CRC_LEN_EN
        return 32'(nbytes);
`else
        return 32'(nbytes) & 32'h0;
`endif
    endfunction

    function automatic exp_t ihdr_exp(input logic [31:0] ww, input logic [31:0] hh,
                                      input logic [7:0] b, input logic [7:0] c);
        logic [7:0] q[$];
        exp_t e;
        q = '{8'h49, 8'h48, 8'h44, 8'h52,
              ww[31:24], ww[23:16], ww[15:8], ww[7:0],
              hh[31:24], hh[23:16], hh[15:8], hh[7:0],
              b, c, 8'h00, 8'h00, 8'h00};
        e.crc = crc_model(q);
        e.typ = 2'd0;
        e.len = exp_len(13);
        return e;
    endfunction

    function automatic exp_t idat_exp(input logic [31:0] bq[$], input logic [3:0] klast);
        logic [7:0]  q[$];
        logic [31:0] x;
        logic [3:0]  k;
        int unsigned cnt;
        exp_t e;
        q = '{8'h49, 8'h44, 8'h41, 8'h54};
        cnt = 0;
        foreach (bq[i]) begin
            x = bq[i];
            k = (i == bq.size() - 1) ? klast : 4'hF;
            for (int b = 0; b < 4; b++) begin
                if (k[3-b]) begin
                    q.push_back(x[31:24]);
                    cnt++;
                end
                x = x << 8;
            end
        end
        e.crc = crc_model(q);
        e.typ = 2'd1;
        e.len = exp_len(cnt);
        return e;
    endfunction

    // Wait for a 32-bit instance result, compare with the scoreboard head, optionally stall, then accept.
    task automatic get32(input string tag, input int hold);
        exp_t e;
        int k;
        k = 0;
        while (!b32.crc_val_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, 64'(b32.crc_val_o), 64'd1);
        if (q32.size() == 0) begin
            chk({tag, "_queue"}, 64'd0, 64'd1);
            return;
        end
        e = q32.pop_front();
        chk({tag, "_crc"}, 64'(b32.crc_dat_o), 64'(e.crc));
        chk({tag, "_typ"}, 64'(b32.crc_typ_o), 64'(e.typ));
        chk({tag, "_len"}, 64'(b32.len_o), 64'(e.len));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_val"}, 64'(b32.crc_val_o), 64'd1);
            chk({tag, "_hold_crc"}, 64'(b32.crc_dat_o), 64'(e.crc));
            chk({tag, "_hold_rdy"}, 64'(b32.rdy_o), 64'd0);
        end
        b32.crc_rdy_i = 1'b1;
        @(negedge clk);
        b32.crc_rdy_i = 1'b0;
    endtask

    task automatic send32(input logic [31:0] bq[$], input logic [3:0] klast, input logic eof);
        int k;
        foreach (bq[i]) begin
            k = 0;
            while (!b32.rdy_o && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (!b32.rdy_o) begin
                chk("send32_rdy_timeout", 64'd0, 64'd1);
                return;
            end
            b32.val_i  = 1'b1;
            b32.dat_i  = bq[i];
            b32.lst_i  = (i == bq.size() - 1);
            b32.keep_i = (i == bq.size() - 1) ? klast : 4'h0;
            b32.eof_i  = eof;
            @(negedge clk);
        end
        b32.val_i = 1'b0;
        b32.lst_i = 1'b0;
        b32.eof_i = 1'b0;
    endtask

    task automatic get64(input string tag, input logic [31:0] crc, input logic [1:0] typ);
        int k;
        k = 0;
        while (!b64.crc_val_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, 64'(b64.crc_val_o), 64'd1);
        chk({tag, "_crc"}, 64'(b64.crc_dat_o), 64'(crc));
        chk({tag, "_typ"}, 64'(b64.crc_typ_o), 64'(typ));
        b64.crc_rdy_i = 1'b1;
        @(negedge clk);
        b64.crc_rdy_i = 1'b0;
    endtask

    task automatic check_reset32(input string tag);
        chk({tag, "_rdy"}, 64'(b32.rdy_o), 64'd0);
        chk({tag, "_val"}, 64'(b32.crc_val_o), 64'd0);
        chk({tag, "_crc"}, 64'(b32.crc_dat_o), 64'd0);
        chk({tag, "_typ"}, 64'(b32.crc_typ_o), 64'd0);
        chk({tag, "_len"}, 64'(b32.len_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy32), 64'd0);
    endtask

    initial begin
        rstn = 1'b1;
        w = '0; h = '0; bd = '0; ct = '0;
        start32 = 1'b0; start64 = 1'b0;
        b32.val_i = 1'b0; b32.dat_i = '0; b32.keep_i = '0; b32.lst_i = 1'b0;
        b32.eof_i = 1'b0; b32.crc_rdy_i = 1'b0;
        b64.val_i = 1'b0; b64.dat_i = '0; b64.keep_i = '0; b64.lst_i = 1'b0;
        b64.eof_i = 1'b0; b64.crc_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset32("reset");
        rstn = 1'b0;
        @(negedge clk);

        // picture 1: reference 1x1 RGBA chunk set
        w = 32'd1; h = 32'd1; bd = 8'd8; ct = 8'd6;
        q32.push_back('{crc: 32'h1F15C489, typ: 2'd0, len: exp_len(13)});
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        chk("busy_after_start", 64'(busy32), 64'd1);
        lat = 1;
        while (!b32.crc_val_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("ihdr_latency", 64'(lat), 64'd6);
        get32("ihdr1", 0);
        beats = '{32'h78DA6364, 32'h60F85F0F, 32'h00028701, 32'h80123456};
        q32.push_back('{crc: 32'hEB47BA92, typ: 2'd1, len: exp_len(13)});
        send32(beats, 4'b1000, 1'b1);
        get32("idat1", 0);
        q32.push_back('{crc: 32'hAE426082, typ: 2'd2, len: 32'd0});
        get32("iend1", 0);
        chk("busy_after_iend", 64'(busy32), 64'd0);

        // picture 2: three IDATs incl. zero-length; stray start during HDR
        w = 32'd640; h = 32'd480; bd = 8'd8; ct = 8'd2;
        q32.push_back(ihdr_exp(32'd640, 32'd480, 8'd8, 8'd2));
        start32 = 1'b1;
        @(negedge clk);
        w = 32'd9; h = 32'd9;
        @(negedge clk);
        start32 = 1'b0;
        get32("ihdr2", 0);
        beats = '{$urandom(), $urandom(), $urandom()};
        q32.push_back(idat_exp(beats, 4'b1100));
        send32(beats, 4'b1100, 1'b0);
        get32("idatA", 0);
        chk("rdy_in_typ", 64'(b32.rdy_o), 64'd0);
        @(negedge clk);
        chk("rdy_in_dat", 64'(b32.rdy_o), 64'd1);
        beats = '{32'hDEADBEEF};
        q32.push_back(idat_exp(beats, 4'b0000));
        send32(beats, 4'b0000, 1'b0);
        get32("idatB_empty", 10);
        beats = '{$urandom(), $urandom()};
        q32.push_back(idat_exp(beats, 4'b1110));
        send32(beats, 4'b1110, 1'b1);
        get32("idatC", 0);
        q32.push_back('{crc: 32'hAE426082, typ: 2'd2, len: 32'd0});
        get32("iend2", 0);

        // picture 3: reset asserted in the middle of a DAT chunk
        w = 32'd1; h = 32'd1; bd = 8'd8; ct = 8'd6;
        q32.push_back(ihdr_exp(32'd1, 32'd1, 8'd8, 8'd6));
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        get32("ihdr3", 0);
        n = 0;
        while (!b32.rdy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        b32.val_i = 1'b1; b32.dat_i = 32'h01020304;
        @(negedge clk);
        b32.val_i = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check_reset32("midreset");
        rstn = 1'b0;
        @(negedge clk);
        q32.push_back('{crc: 32'h1F15C489, typ: 2'd0, len: exp_len(13)});
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        get32("ihdr_after_reset", 0);

        // 64-bit data path: same IDAT bytes in two beats
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        get64("w64_ihdr", 32'h1F15C489, 2'd0);
        n = 0;
        while (!b64.rdy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w64_rdy", 64'(b64.rdy_o), 64'd1);
        b64.val_i = 1'b1; b64.dat_i = 64'h78DA636460F85F0F; b64.keep_i = 8'h00;
        b64.lst_i = 1'b0; b64.eof_i = 1'b0;
        @(negedge clk);
        b64.dat_i = 64'h0002870180ABCDEF; b64.keep_i = 8'b11111000;
        b64.lst_i = 1'b1; b64.eof_i = 1'b1;
        @(negedge clk);
        b64.val_i = 1'b0; b64.lst_i = 1'b0; b64.eof_i = 1'b0;
        get64("w64_idat", 32'hEB47BA92, 2'd1);
        get64("w64_iend", 32'hAE426082, 2'd2);
        chk("w64_busy_end", 64'(busy64), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
